// File: rtl/shifter_iter.sv
// Multi-cycle shifter: at most 2**STEP_LOG2 positions per clock, valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to enable rotate modes 3/4 (else they act as SLL/SRL).
module shifter_iter #(
  parameter int WIDTH     = 32,
  parameter int STEP_LOG2 = 2,
  localparam int SHW      = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN,
  input  logic [SHW-1:0]   SHFT,
  input  logic [2:0]       SEL,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT
);

  localparam int STEP_I = 1 << STEP_LOG2;
  localparam logic [SHW-1:0] STEP = STEP_I[SHW-1:0];

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ROL,
    OP_ROR
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q, op_dec;
  logic             fill_q;
  logic [SHW-1:0]   rem_q;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] pre_val;
  logic [WIDTH-1:0] step_val;
  logic             accept;

  assign IN_READY  = (state == IDLE);
  assign OUT_VALID = (state == DONE);
  assign OUT       = work_q;
  assign accept    = IN_VALID && IN_READY;

  always_comb begin
    op_dec = OP_SLL;
    unique case (SEL)
      3'd1: op_dec = OP_SRL;
      3'd2: op_dec = OP_SRA;
`ifdef SHIFTER_ROTATE_EN
      3'd3: op_dec = OP_ROL;
      3'd4: op_dec = OP_ROR;
`else
      3'd3: op_dec = OP_SLL;
      3'd4: op_dec = OP_SRL;
`endif
      default: op_dec = OP_SLL;
    endcase
  end

  always_comb begin
    pre_val = IN;
    unique case (SEL)
      3'd5: pre_val = {{(WIDTH-8){IN[7]}}, IN[7:0]};
      3'd6: pre_val = {{(WIDTH-16){IN[15]}}, IN[15:0]};
      default: pre_val = IN;
    endcase
  end

  assign amt = (rem_q > STEP) ? STEP : rem_q;

`ifdef SHIFTER_ROTATE_EN
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;
  assign rol_w = {work_q, work_q} << amt;
  assign ror_w = {work_q, work_q} >> amt;
`endif

  always_comb begin
    step_val = work_q << amt;
    unique case (op_q)
      OP_SRL: step_val = work_q >> amt;
      OP_SRA: step_val = (work_q >> amt)
                       | (fill_q ? ~({WIDTH{1'b1}} >> amt) : '0);
`ifdef SHIFTER_ROTATE_EN
      OP_ROL: step_val = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR: step_val = ror_w[WIDTH-1:0];
`endif
      default: step_val = work_q << amt;
    endcase
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (FLUSH) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (IN_VALID)
                state_nxt = (SHFT == '0) ? DONE : BUSY;
        BUSY: if (rem_q <= STEP)
                state_nxt = DONE;
        DONE: if (OUT_READY)
                state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FLUSH freezes the working register; only the counter is cleared
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      work_q <= '0;
      rem_q  <= '0;
      op_q   <= OP_SLL;
      fill_q <= 1'b0;
    end else if (FLUSH) begin
      rem_q <= '0;
    end else if (accept) begin
      work_q <= pre_val;
      rem_q  <= SHFT;
      op_q   <= op_dec;
      fill_q <= (op_dec == OP_SRA) && IN[WIDTH-1];
    end else if (state == BUSY) begin
      work_q <= step_val;
      rem_q  <= rem_q - amt;
    end
  end

`ifdef FORMAL
  function automatic logic [WIDTH-1:0] golden(
    input logic [2:0]       s,
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   n
  );
    logic [WIDTH-1:0] r;
    unique case (s)
      3'd1: r = d >> n;
      3'd2: r = $unsigned($signed(d) >>> n);
      3'd3: r = (d << n) | (d >> (WIDTH - int'(n)));
      3'd4: r = (d >> n) | (d << (WIDTH - int'(n)));
      3'd5: r = {{(WIDTH-8){d[7]}}, d[7:0]} << n;
      3'd6: r = {{(WIDTH-16){d[15]}}, d[15:0]} << n;
      default: r = d << n;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] exp_q;
  logic             chk_q;
  state_t           prev_q;

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      exp_q  <= '0;
      chk_q  <= 1'b0;
      prev_q <= IDLE;
    end else begin
      prev_q <= state;
      if (accept && !FLUSH) begin
        exp_q <= golden(SEL, IN, SHFT);
`ifdef SHIFTER_ROTATE_EN
        chk_q <= 1'b1;
`else
        chk_q <= (SEL != 3'd3) && (SEL != 3'd4);
`endif
      end
      if (state == DONE && prev_q != DONE && chk_q)
        assert (work_q == exp_q);
    end
  end
`endif

endmodule

// File: tb/tb_shifter_iter.sv
// Directed bench for shifter_iter (WIDTH=32, STEP_LOG2=2).
// Rotate expectations follow SHIFTER_ROTATE_EN.
module tb_shifter_iter;

  localparam int WIDTH     = 32;
  localparam int STEP_LOG2 = 2;

  logic        CLK = 1'b0;
  logic        N_RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] IN = '0;
  logic [4:0]  SHFT = '0;
  logic [2:0]  SEL = '0;
  logic        FLUSH = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT;

  int checks = 0;
  int errors = 0;

  shifter_iter #(
    .WIDTH(WIDTH),
    .STEP_LOG2(STEP_LOG2)
  ) dut (
    .CLK(CLK),
    .N_RST(N_RST),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .IN(IN),
    .SHFT(SHFT),
    .SEL(SEL),
    .FLUSH(FLUSH),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT(OUT)
  );

  always #5 CLK = ~CLK;

  task automatic start_op(
    input logic [2:0]  s,
    input logic [31:0] d,
    input logic [4:0]  n
  );
    @(negedge CLK);
    IN_VALID = 1'b1;
    SEL = s;
    IN = d;
    SHFT = n;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN = '1;
    SHFT = '1;
    SEL = 3'd2;
  endtask

  task automatic wait_done(output int cyc, output logic rdy_seen);
    cyc = 0;
    rdy_seen = 1'b0;
    while (cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (OUT_VALID) break;
      if (IN_READY) rdy_seen = 1'b1;
    end
  endtask

  task automatic release_out();
    @(negedge CLK);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    N_RST = 1'b0;
    #12;
    checks++;
    if (OUT !== 32'h0) begin
      errors++;
      $display("FAIL reset_out: got %h want %h", OUT, 32'h0);
    end
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", OUT_VALID);
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    end
    @(negedge CLK);
    N_RST = 1'b1;
  endtask

  task automatic test_sll_latency();
    int   cyc;
    logic rs;
    start_op(3'd0, 32'h0000_0001, 5'd31);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("FAIL sll31_latency: got %0d want 9", cyc);
    end
    checks++;
    if (OUT !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll31_out: got %h want 80000000", OUT);
    end
    checks++;
    if (rs !== 1'b0) begin
      errors++;
      $display("FAIL sll31_busy_ready: got %b want 0", rs);
    end
    release_out();
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL sll31_idle: got rdy=%b vld=%b want 1/0",
               IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_shift_right();
    int   cyc;
    logic rs;
    start_op(3'd2, 32'h8000_0000, 5'd4);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("FAIL sra4_latency: got %0d want 2", cyc);
    end
    checks++;
    if (OUT !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra4_out: got %h want f8000000", OUT);
    end
    release_out();
    start_op(3'd1, 32'h8000_0000, 5'd4);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 2 || OUT !== 32'h0800_0000) begin
      errors++;
      $display("FAIL srl4: got %h cyc %0d want 08000000 cyc 2",
               OUT, cyc);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic rs;
    start_op(3'd1, 32'h1234_5678, 5'd0);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 1 || OUT !== 32'h1234_5678) begin
      errors++;
      $display("FAIL srl0: got %h cyc %0d want 12345678 cyc 1",
               OUT, cyc);
    end
    IN_VALID = 1'b1;
    IN = 32'hDEAD_BEEF;
    SHFT = 5'd3;
    SEL = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (OUT !== 32'h1234_5678 || IN_READY !== 1'b0 ||
          OUT_VALID !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d: got out=%h rdy=%b vld=%b want 12345678/0/1",
                 i, OUT, IN_READY, OUT_VALID);
      end
    end
    IN_VALID = 1'b0;
    release_out();
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got rdy=%b vld=%b want 1/0",
               IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_rotate();
    int          cyc;
    logic        rs;
    logic [31:0] exp;
`ifdef SHIFTER_ROTATE_EN
    exp = 32'h1000_000F;
`else
    exp = 32'h0000_000F;
`endif
    start_op(3'd4, 32'h0000_00F1, 5'd4);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 2 || OUT !== exp) begin
      errors++;
      $display("FAIL ror4: got %h cyc %0d want %h cyc 2", OUT, cyc, exp);
    end
    release_out();
  endtask

  task automatic test_sext();
    int   cyc;
    logic rs;
    start_op(3'd5, 32'h0000_0080, 5'd8);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 3 || OUT !== 32'hFFFF_8000) begin
      errors++;
      $display("FAIL sext8: got %h cyc %0d want ffff8000 cyc 3",
               OUT, cyc);
    end
    release_out();
    start_op(3'd6, 32'h0000_8001, 5'd1);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 2 || OUT !== 32'hFFFF_0002) begin
      errors++;
      $display("FAIL sext16: got %h cyc %0d want ffff0002 cyc 2",
               OUT, cyc);
    end
    release_out();
  endtask

  task automatic test_flush();
    logic seen;
    start_op(3'd0, 32'h0000_0001, 5'd20);
    @(posedge CLK);
    #1;
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    FLUSH = 1'b0;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got rdy=%b vld=%b want 1/0",
               IN_READY, OUT_VALID);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (OUT_VALID) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_valid: got %b want 0", seen);
    end
    @(negedge CLK);
    IN_VALID = 1'b1;
    FLUSH = 1'b1;
    SHFT = 5'd0;
    SEL = 3'd0;
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    FLUSH = 1'b0;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL flush_beats_accept: got rdy=%b vld=%b want 1/0",
               IN_READY, OUT_VALID);
    end
  endtask

  task automatic test_reset_abort();
    int   cyc;
    logic rs;
    start_op(3'd0, 32'h0000_0001, 5'd20);
    @(negedge CLK);
    @(negedge CLK);
    #2;
    N_RST = 1'b0;
    #1;
    checks++;
    if (OUT !== 32'h0 || OUT_VALID !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got out=%h vld=%b rdy=%b want 0/0/1",
               OUT, OUT_VALID, IN_READY);
    end
    @(negedge CLK);
    N_RST = 1'b1;
    start_op(3'd0, 32'h0000_0003, 5'd5);
    wait_done(cyc, rs);
    checks++;
    if (cyc !== 3 || OUT !== 32'h0000_0060) begin
      errors++;
      $display("FAIL post_reset: got %h cyc %0d want 00000060 cyc 3",
               OUT, cyc);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_sll_latency();
    test_shift_right();
    test_backpressure();
    test_rotate();
    test_sext();
    test_flush();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
